// File: rtl/lut_ram_loader.sv
// Byte-stream to LUT RAM loader: packs bytes little-endian into words and writes
// them to consecutive addresses from 0, with done/err status and a running checksum.
module lut_ram_loader #(
  parameter int LUT_WIDTH = 32,
  parameter int LUT_DEPTH = 256,
  localparam int AW = $clog2(LUT_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [AW:0]          num_words,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_data,
  output logic                 byte_ready,
  output logic                 wr_en,
  output logic [AW-1:0]        wr_addr,
  output logic [LUT_WIDTH-1:0] wr_data,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [LUT_WIDTH-1:0] checksum
);

  localparam int BPW = LUT_WIDTH / 8;
  localparam int BIW = (BPW > 1) ? $clog2(BPW) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]           r_state;
  logic                 r_ready;
  logic                 r_wr_en;
  logic [AW-1:0]        r_wr_addr;
  logic [LUT_WIDTH-1:0] r_wr_data;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_err;
  logic [LUT_WIDTH-1:0] r_checksum;
  logic [AW:0]          r_num_words;
  logic [AW:0]          r_word_cnt;
  logic [BIW-1:0]       r_byte_idx;
  logic [LUT_WIDTH-1:0] r_asm;

  logic                 w_accept;
  logic                 w_last_byte;
  logic                 w_last_word;
  logic [LUT_WIDTH-1:0] w_word;

  assign w_accept    = byte_valid && r_ready;
  assign w_last_byte = (r_byte_idx == BIW'(BPW - 1));
  assign w_last_word = ((r_word_cnt + (AW + 1)'(1)) == r_num_words);

  // Assembled word including the byte on the bus, so the final byte is written without an extra cycle.
  always_comb begin
    w_word = r_asm;
    w_word[8*r_byte_idx +: 8] = byte_data;
  end

  // Control FSM, write port and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ready     <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_checksum  <= '0;
      r_num_words <= '0;
      r_word_cnt  <= '0;
      r_byte_idx  <= '0;
      r_asm       <= '0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_checksum <= '0;
            if (num_words == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_err   <= 1'b0;
            end else if (num_words > (AW + 1)'(LUT_DEPTH)) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else begin
              r_state     <= S_LOAD;
              r_ready     <= 1'b1;
              r_busy      <= 1'b1;
              r_done      <= 1'b0;
              r_err       <= 1'b0;
              r_num_words <= num_words;
              r_word_cnt  <= '0;
              r_byte_idx  <= '0;
              r_asm       <= '0;
            end
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            if (w_last_byte) begin
              r_wr_en    <= 1'b1;
              r_wr_addr  <= r_word_cnt[AW-1:0];
              r_wr_data  <= w_word;
              r_checksum <= r_checksum + w_word;
              r_word_cnt <= r_word_cnt + (AW + 1)'(1);
              r_byte_idx <= '0;
              r_asm      <= '0;
              if (w_last_word) begin
                r_state <= S_DRAIN;
                r_ready <= 1'b0;
              end
            end else begin
              r_asm      <= w_word;
              r_byte_idx <= r_byte_idx + BIW'(1);
            end
          end
        end
        S_DRAIN: begin
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign byte_ready = r_ready;
  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign checksum   = r_checksum;

endmodule

// File: tb/tb_lut_ram_loader.sv
// Scoreboard bench for lut_ram_loader: a word-level model queues expected writes,
// a negedge monitor pops and compares them whenever wr_en is seen.
module tb_lut_ram_loader;
  localparam int W  = 32;
  localparam int D  = 256;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   num_words;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          busy;
  logic          done;
  logic          err;
  logic [W-1:0]  checksum;

  lut_ram_loader #(.LUT_WIDTH(W), .LUT_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .done(done), .err(err), .checksum(checksum)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
    logic [W-1:0]  csum;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_wr_cyc = -1;
  int   wr_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Monitor: every observed write is matched against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && wr_en) begin
      exp_t e;
      wr_cnt++;
      last_wr_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wr: got addr %0h data %0h expected no write", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", wr_addr, e.addr);
        chk("wr_data", wr_data, e.data);
        chk("checksum_run", checksum, e.csum);
      end
    end
  end

  task automatic start_pulse(input int n);
    @(posedge clk); #1;
    start = 1'b1;
    num_words = n[AW:0];
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int stall);
    int k;
    repeat (stall) begin
      byte_valid = 1'b0;
      @(negedge clk);
      chk("ready_in_stall", byte_ready, 1'b1);
      @(posedge clk); #1;
    end
    byte_valid = 1'b1;
    byte_data  = b;
    k = 0;
    @(negedge clk);
    while (!byte_ready && k < 20) begin
      k++;
      @(negedge clk);
    end
    if (k >= 20) chk("ready_timeout", byte_ready, 1'b1);
    @(posedge clk); #1;
  endtask

  // Reference model: words from byte list by plain arithmetic, pushed with the running checksum.
  task automatic plan(input int n, input logic [7:0] bytes[$], output logic [W-1:0] sum);
    logic [W-1:0] word;
    sum = '0;
    for (int w = 0; w < n; w++) begin
      word = '0;
      for (int k = 0; k < 4; k++) word = word | (W'(bytes[w*4+k]) << (8*k));
      sum = sum + word;
      exp_q.push_back('{addr: w[AW-1:0], data: word, csum: sum});
    end
  endtask

  // mode 0: random data and stalls; 1: bytes 01.. back-to-back; 2: same with fixed stalls;
  // 3: all FF; 4: random data with start pulsed mid-load.
  task automatic run_load(input int n, input int mode);
    logic [7:0]   bytes[$];
    logic [W-1:0] sum;
    int           wr0, st, k;
    bytes.delete();
    for (int i = 0; i < n*4; i++) begin
      if (mode == 1 || mode == 2) bytes.push_back(8'(i + 1));
      else if (mode == 3)         bytes.push_back(8'hFF);
      else                        bytes.push_back(8'($urandom));
    end
    plan(n, bytes, sum);
    wr0 = wr_cnt;
    start_pulse(n);
    chk("start_done_clr", done, 1'b0);
    chk("start_err_clr", err, 1'b0);
    chk("start_csum_clr", checksum, '0);
    chk("start_busy", busy, 1'b1);
    for (int i = 0; i < n*4; i++) begin
      if (mode == 2)      st = (i == 2) ? 3 : ((i == 6) ? 5 : 0);
      else if (mode == 0) st = ($urandom_range(0, 9) < 3) ? $urandom_range(1, 3) : 0;
      else                st = 0;
      if (mode == 4 && i == 3) begin
        start = 1'b1;
        num_words = '0;
      end else begin
        start = 1'b0;
      end
      send_byte(bytes[i], st);
    end
    start = 1'b0;
    byte_valid = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < 20);
    chk("done", done, 1'b1);
    chk("done_latency", cyc, last_wr_cyc + 1);
    chk("err_after_load", err, 1'b0);
    chk("checksum_final", checksum, sum);
    chk("busy_after_load", busy, 1'b0);
    chk("ready_after_load", byte_ready, 1'b0);
    chk("wr_count", wr_cnt - wr0, n);
    chk("scoreboard_empty", exp_q.size(), 0);
  endtask

  task automatic run_reject(input int n, input logic exp_err);
    int wr0;
    wr0 = wr_cnt;
    start_pulse(n);
    byte_valid = 1'b1;
    byte_data  = 8'($urandom);
    chk("rej_done", done, 1'b1);
    chk("rej_err", err, exp_err);
    chk("rej_busy", busy, 1'b0);
    chk("rej_csum", checksum, '0);
    repeat (4) begin
      @(negedge clk);
      chk("rej_ready", byte_ready, 1'b0);
    end
    @(posedge clk); #1;
    byte_valid = 1'b0;
    chk("rej_no_wr", wr_cnt - wr0, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_wr_en"}, wr_en, 1'b0);
    chk({tag, "_wr_addr"}, wr_addr, '0);
    chk({tag, "_wr_data"}, wr_data, '0);
    chk({tag, "_checksum"}, checksum, '0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_ready"}, byte_ready, 1'b0);
  endtask

  initial begin
    logic [7:0]   bytes[$];
    logic [W-1:0] sum;
    int           wr0;
    rst = 1'b1; start = 1'b0; num_words = '0; byte_valid = 1'b0; byte_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    run_load(2, 1);
    chk("basic_csum_const", checksum, 32'h0C0A0806);
    run_load(2, 2);
    chk("stall_csum_const", checksum, 32'h0C0A0806);
    run_reject(0, 1'b0);
    run_reject(257, 1'b1);
    run_load(256, 3);
    chk("full_last_addr", wr_addr, 8'd255);
    chk("full_csum_const", checksum, 32'hFFFFFF00);

    // Reset after 5 of 8 bytes: only word 0 is written, everything clears.
    bytes.delete();
    for (int i = 0; i < 8; i++) bytes.push_back(8'($urandom));
    plan(2, bytes, sum);
    wr0 = wr_cnt;
    start_pulse(2);
    for (int i = 0; i < 5; i++) send_byte(bytes[i], 0);
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    chk("midrst_wr_count", wr_cnt - wr0, 1);
    exp_q.delete();
    byte_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_no_late_wr", wr_cnt - wr0, 1);
    run_load(1, 0);

    run_load(3, 4);
    for (int r = 0; r < 6; r++) run_load($urandom_range(1, 8), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
